lcd_timing_gen: RTL and testbench
=================================

# lcd_timing_gen

Parametrised RGB565 parallel-LCD timing and test-pattern generator. It runs from the single system clock and produces the panel pixel clock internally with a clock-enable divider, so no separate PLL divided output is needed. Sync/porch geometry, sync polarity and pixel divisor are set by parameters. A run-time mode selects one of four test patterns. It sits between the PLL system clock and the LCD pins in the top level.

## Interface
- `H_ACTIVE`, 480, visible pixels per line; must be a multiple of 8.
- `H_FP`, 8, horizontal front porch, in pixels.
- `H_SYNC`, 4, horizontal sync width, in pixels.
- `H_BP`, 33, horizontal back porch; default H_TOTAL = 525.
- `V_ACTIVE`, 272, visible lines.
- `V_FP`, 4, vertical front porch, in lines.
- `V_SYNC`, 4, vertical sync width, in lines.
- `V_BP`, 8, vertical back porch; default V_TOTAL = 288.
- `PIX_DIV`, 10, CLK cycles per pixel; must be ≥2. The default gives 90 MHz → 9 MHz.
- `SYNC_POL`, 0, sync active level: 0 = active-low, 1 = active-high.

Ports:
- `CLK`  in  1  system clock; the only clock.
- `nRST`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable.
- `mode`  in  2  pattern select: 0 bars, 1 checker, 2 gradient, 3 solid.
- `solid_rgb`  in  16  RGB565 colour for mode 3.
- `LCD_CLK`  out  1  pixel clock to the panel.
- `LCD_HSYNC`, `LCD_VSYNC`  out  1 each  sync outputs.
- `LCD_DE`  out  1  data enable.
- `LCD_R`  out  5  red.
- `LCD_G`  out  6  green.
- `LCD_B`  out  5  blue.
- `frame_start`  out  1  one-CLK pulse at the start of pixel (0,0).
- `frame_cnt`  out  8  completed-frame counter; wraps 255→0.

## Operation
- **Divider.** `div` counts 0..PIX_DIV-1. `pix_ce` is asserted when `div` = PIX_DIV-1.
- **Pixel counters.** On `pix_ce`, `h` advances 0..H_TOTAL-1. When `h` wraps, `v` advances 0..V_TOTAL-1. Both counters are 11 bits; H_TOTAL and V_TOTAL must be ≤2047.
- **Pixel period.** Each pixel period is PIX_DIV CLK cycles and starts on the cycle after `pix_ce`.
- **LCD_CLK.** Low for the first PIX_DIV/2 cycles (floor) of each period, high for the rest. The panel samples on the rising edge, mid-period.
- **Registered outputs.** All outputs are registered and change only at period start. They reflect the (h,v) of that period.
- **DE.** `LCD_DE` = (h < H_ACTIVE) && (v < V_ACTIVE).
- **HSYNC.** Active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
- **VSYNC.** Active for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. It is evaluated per pixel, so edges align with h=0.
- **Blanking.** RGB = 0 whenever DE = 0.
- **Mode latch.** `mode` and `solid_rgb` are sampled only at the start of pixel (0,0). A change mid-frame takes effect at the next frame.
- **Patterns** (x = h, or the scrolled x defined in Configuration; y = v):
  - Mode 0, bars: BAR_W = H_ACTIVE/8. Bar index k = x/BAR_W via a comparator chain. Bars in order: white, yellow, cyan, green, magenta, red, blue, black.
  - Mode 1, checker: white when x[4]^y[4] = 0, else black.
  - Mode 2, gradient: R = x[7:3], G = y[7:2], B = (x+y)[7:3].
  - Mode 3, solid: R,G,B = latched `solid_rgb`[15:11], [10:5], [4:0].
- **frame_start.** Pulses for one CLK cycle at the first cycle of pixel (0,0).
- **frame_cnt.** Increments on the same cycle as `frame_start`, except for the first frame after `en` rises.
- **en low.** `div`, `h` and `v` are held at 0, and all outputs are held at their reset values.
- **en rising.** Pixel (0,0) begins on the next CLK cycle and `frame_start` pulses.
- **en falling mid-frame.** Outputs return to reset values on the next cycle. `frame_cnt` is held, not cleared.

## Timing
- **Reset values:**
  - `LCD_CLK` = 0, `LCD_DE` = 0, RGB = 0.
  - `LCD_HSYNC` and `LCD_VSYNC` = ~SYNC_POL (inactive).
  - `frame_start` = 0, `frame_cnt` = 0.
  - Internal `div`/`h`/`v` = 0; latched mode = 0.
- **Reset assertion** is immediate and asynchronous. Release is synchronous to CLK; the first frame starts the cycle after release with `en` = 1.
- **Latency:** 0 pixel periods from counter position to pins. Outputs for (h,v) are valid for the whole period in which the counters equal (h,v).
- **Frame length:** H_TOTAL × V_TOTAL × PIX_DIV CLK cycles. The default is 1,512,000 (59.5 Hz at 90 MHz).
- **Odd PIX_DIV:** LCD_CLK has its low phase one cycle shorter than its high phase (e.g. PIX_DIV = 3: low 1, high 2).

## Configuration
- `LCD_PATTERN_SCROLL_EN` defined:
  - Modes 0–2 use x = (h + frame_cnt) wrapped at H_ACTIVE, implemented as a single conditional subtract.
  - Requires H_ACTIVE ≥ 256.
  - Mode 3 is unaffected.
- Undefined: x = h, the patterns are static, and no adder is synthesised.

## Test plan
- Sim params H 16/2/2/2, V 8/1/1/1, PIX_DIV = 4, SYNC_POL = 0, `en` = 1 → frame = 22×11×4 = 968 CLK cycles.
  - `LCD_HSYNC` low for h = 18..19 (8 CLK cycles).
  - `LCD_VSYNC` low for v = 9.
  - `LCD_DE` high for 16 pixels on each of lines 0–7.
- Same params: `LCD_CLK` pattern is 0,0,1,1 per pixel. RGB changes only on the cycle LCD_CLK falls.
- Mode 0, H_ACTIVE = 16 → 8 bars of 2 pixels: pixels 0–1 = 16'hFFFF, 2–3 = 16'hFFE0, …, 14–15 = 16'h0000. Blanking pixels = 0.
- Mode switch 0→3 with `solid_rgb` = 16'hF800 at line 3 → the rest of the frame stays bars. Next frame all DE pixels are R = 31, G = 0, B = 0.
- `nRST` low mid-line → outputs take reset values within the same cycle. After release, `frame_start` pulses one cycle later and `frame_cnt` = 0.
- `en` low for 100 cycles mid-frame → outputs idle and `frame_cnt` held. `en` high → `frame_start` pulses next cycle and `frame_cnt` increments every 968 cycles thereafter, wrapping 255→0.

Source files
------------

// File: rtl/lcd_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lcd_timing_gen
// Description : RGB565 parallel-LCD timing and test-pattern generator with an
//               internal clock-enable pixel divider. Optional horizontal
//               pattern scroll is enabled by defining LCD_PATTERN_SCROLL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_timing_gen #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 33,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 8,
    parameter int PIX_DIV  = 10,
    parameter int SYNC_POL = 0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [15:0] solid_rgb,
    output logic        LCD_CLK,
    output logic        LCD_HSYNC,
    output logic        LCD_VSYNC,
    output logic        LCD_DE,
    output logic [4:0]  LCD_R,
    output logic [5:0]  LCD_G,
    output logic [4:0]  LCD_B,
    output logic        frame_start,
    output logic [7:0]  frame_cnt
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_DW      = $clog2(PIX_DIV);

    localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(PIX_DIV - 1);
    localparam logic [c_DW-1:0] c_DIV_HALF = c_DW'(PIX_DIV / 2);
    localparam logic [10:0] c_H_LAST  = 11'(c_H_TOTAL - 1);
    localparam logic [10:0] c_V_LAST  = 11'(c_V_TOTAL - 1);
    localparam logic [10:0] c_H_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0] c_V_ACT   = 11'(V_ACTIVE);
    localparam logic [10:0] c_HS_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] c_VS_BEG  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [10:0] c_BAR_W   = 11'(H_ACTIVE / 8);
    localparam logic        c_SYNC_ON = (SYNC_POL != 0);

    logic [c_DW-1:0] r_div;
    logic [10:0]     r_h;
    logic [10:0]     r_v;
    logic            r_run;
    logic [1:0]      r_mode;
    logic [15:0]     r_solid;

    logic [c_DW-1:0] w_div_nxt;
    logic [10:0]     w_h_nxt;
    logic [10:0]     w_v_nxt;
    logic            w_pix_ce;
    logic            w_start;
    logic            w_adv;
    logic            w_period;
    logic            w_frame_first;
    logic [7:0]      w_fc_nxt;
    logic [1:0]      w_mode_eff;
    logic [15:0]     w_solid_eff;
    logic [10:0]     w_x;
    logic [2:0]      w_bar;
    logic [15:0]     w_rgb;
    logic            w_de;
    logic            w_hs_act;
    logic            w_vs_act;

    // A new pixel period begins either on the first enabled cycle or after pix_ce.
    assign w_pix_ce = (r_div == c_DIV_LAST);
    assign w_start  = en && !r_run;
    assign w_adv    = en && r_run && w_pix_ce;
    assign w_period = w_start || w_adv;

    always_comb begin
        w_div_nxt = '0;
        w_h_nxt   = r_h;
        w_v_nxt   = r_v;
        if (!en || w_start) begin
            w_h_nxt = '0;
            w_v_nxt = '0;
        end else if (w_pix_ce) begin
            if (r_h == c_H_LAST) begin
                w_h_nxt = '0;
                w_v_nxt = (r_v == c_V_LAST) ? 11'd0 : r_v + 11'd1;
            end else begin
                w_h_nxt = r_h + 11'd1;
            end
        end else begin
            w_div_nxt = r_div + 1'b1;
        end
    end

    assign w_frame_first = w_period && (w_h_nxt == 11'd0) && (w_v_nxt == 11'd0);
    // The first frame after enable is not a completed frame.
    assign w_fc_nxt      = (w_adv && w_frame_first) ? frame_cnt + 8'd1 : frame_cnt;
    assign w_mode_eff    = w_frame_first ? mode : r_mode;
    assign w_solid_eff   = w_frame_first ? solid_rgb : r_solid;

    assign w_de     = (w_h_nxt < c_H_ACT) && (w_v_nxt < c_V_ACT);
    assign w_hs_act = (w_h_nxt >= c_HS_BEG) && (w_h_nxt <= c_HS_END);
    assign w_vs_act = (w_v_nxt >= c_VS_BEG) && (w_v_nxt <= c_VS_END);

`ifdef LCD_PATTERN_SCROLL_EN
    logic [10:0] w_xs;
    // h + frame_cnt stays below 2*H_ACTIVE inside the active area, so one subtract wraps it.
    assign w_xs = w_h_nxt + {3'b000, w_fc_nxt};
    assign w_x  = (w_xs >= c_H_ACT) ? w_xs - c_H_ACT : w_xs;
`else
    assign w_x  = w_h_nxt;
`endif

    always_comb begin
        w_bar = '0;
        for (int i = 1; i < 8; i++) begin
            if (w_x >= 11'(i) * c_BAR_W) begin
                w_bar = w_bar + 3'd1;
            end
        end
    end

    always_comb begin
        w_rgb = '0;
        case (w_mode_eff)
            2'd0: begin
                case (w_bar)
                    3'd0:    w_rgb = 16'hFFFF;
                    3'd1:    w_rgb = 16'hFFE0;
                    3'd2:    w_rgb = 16'h07FF;
                    3'd3:    w_rgb = 16'h07E0;
                    3'd4:    w_rgb = 16'hF81F;
                    3'd5:    w_rgb = 16'hF800;
                    3'd6:    w_rgb = 16'h001F;
                    default: w_rgb = 16'h0000;
                endcase
            end
            2'd1:    w_rgb = (w_x[4] ^ w_v_nxt[4]) ? 16'h0000 : 16'hFFFF;
            2'd2:    w_rgb = {w_x[7:3], w_v_nxt[7:2], 5'((w_x[7:0] + w_v_nxt[7:0]) >> 3)};
            default: w_rgb = w_solid_eff;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_div       <= '0;
            r_h         <= '0;
            r_v         <= '0;
            r_run       <= 1'b0;
            r_mode      <= '0;
            r_solid     <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            LCD_CLK     <= 1'b0;
            LCD_HSYNC   <= ~c_SYNC_ON;
            LCD_VSYNC   <= ~c_SYNC_ON;
            LCD_DE      <= 1'b0;
            LCD_R       <= '0;
            LCD_G       <= '0;
            LCD_B       <= '0;
        end else begin
            r_run       <= en;
            r_div       <= w_div_nxt;
            r_h         <= w_h_nxt;
            r_v         <= w_v_nxt;
            frame_cnt   <= w_fc_nxt;
            frame_start <= w_frame_first;
            LCD_CLK     <= en && (w_div_nxt >= c_DIV_HALF);
            if (w_frame_first) begin
                r_mode  <= mode;
                r_solid <= solid_rgb;
            end
            if (!en) begin
                LCD_HSYNC <= ~c_SYNC_ON;
                LCD_VSYNC <= ~c_SYNC_ON;
                LCD_DE    <= 1'b0;
                LCD_R     <= '0;
                LCD_G     <= '0;
                LCD_B     <= '0;
            end else if (w_period) begin
                LCD_HSYNC <= w_hs_act ? c_SYNC_ON : ~c_SYNC_ON;
                LCD_VSYNC <= w_vs_act ? c_SYNC_ON : ~c_SYNC_ON;
                LCD_DE    <= w_de;
                {LCD_R, LCD_G, LCD_B} <= w_de ? w_rgb : 16'h0000;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lcd_timing_gen
// Description : Scoreboard bench for lcd_timing_gen (small panel geometry plus
//               a tiny instance for frame counter wrap and odd divisor).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_timing_gen;

    localparam int HT  = 22;
    localparam int VT  = 11;
    localparam int DIV = 4;
    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    typedef struct packed {
        logic        clk;
        logic        hs;
        logic        vs;
        logic        de;
        logic [15:0] rgb;
        logic        fs;
        logic [7:0]  fc;
    } exp_t;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        en;
    logic [1:0]  mode;
    logic [15:0] solid_rgb;
    logic        LCD_CLK, LCD_HSYNC, LCD_VSYNC, LCD_DE, frame_start;
    logic [4:0]  LCD_R, LCD_B;
    logic [5:0]  LCD_G;
    logic [7:0]  frame_cnt;

    logic        rst_w_n;
    logic        clk_w, hs_w, vs_w, de_w, fs_w;
    logic [4:0]  r_w, b_w;
    logic [5:0]  g_w;
    logic [7:0]  fc_w;

    always #5 CLK = ~CLK;

    lcd_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(1), .V_BP(1),
        .PIX_DIV(DIV), .SYNC_POL(0)
    ) dut (
        .CLK(CLK), .nRST(nRST), .en(en), .mode(mode), .solid_rgb(solid_rgb),
        .LCD_CLK(LCD_CLK), .LCD_HSYNC(LCD_HSYNC), .LCD_VSYNC(LCD_VSYNC),
        .LCD_DE(LCD_DE), .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    // 11 x 4 pixels at 3 clocks each: 132 clocks per frame.
    lcd_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(1), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .PIX_DIV(3),  .SYNC_POL(0)
    ) dut_w (
        .CLK(CLK), .nRST(rst_w_n), .en(1'b1), .mode(2'd0), .solid_rgb(16'h0000),
        .LCD_CLK(clk_w), .LCD_HSYNC(hs_w), .LCD_VSYNC(vs_w),
        .LCD_DE(de_w), .LCD_R(r_w), .LCD_G(g_w), .LCD_B(b_w),
        .frame_start(fs_w), .frame_cnt(fc_w)
    );

    exp_t       sb[$];
    logic [7:0] q_w[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic       w_done  = 1'b0;

    logic        m_run = 1'b0;
    int          m_t   = 0;
    int          m_h   = 0;
    int          m_v   = 0;
    logic [7:0]  m_fc  = '0;
    logic [1:0]  m_mode = '0;
    logic [15:0] m_solid = '0;

    function automatic exp_t actual();
        return {LCD_CLK, LCD_HSYNC, LCD_VSYNC, LCD_DE, LCD_R, LCD_G, LCD_B, frame_start, frame_cnt};
    endfunction

    function automatic logic [15:0] pat(logic [1:0] m, logic [15:0] s, int h, int v);
        logic [7:0] hb;
        logic [7:0] vb;
        logic [7:0] sum;
        hb  = 8'(h);
        vb  = 8'(v);
        sum = 8'(h + v);
        case (m)
            2'd0:    return BARS[h / 2];
            2'd1:    return (hb[4] ^ vb[4]) ? 16'h0000 : 16'hFFFF;
            2'd2:    return {hb[7:3], vb[7:2], sum[7:3]};
            default: return s;
        endcase
    endfunction

    task automatic check_px(string name, exp_t got, exp_t want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s t=%0t got clk=%b hs=%b vs=%b de=%b rgb=%h fs=%b fc=%0d want clk=%b hs=%b vs=%b de=%b rgb=%h fs=%b fc=%0d",
                     name, $time, got.clk, got.hs, got.vs, got.de, got.rgb, got.fs, got.fc,
                     want.clk, want.hs, want.vs, want.de, want.rgb, want.fs, want.fc);
        end
    endtask

    task automatic check_val(string name, int got, int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
        end
    endtask

    // Expected outputs after the next edge, pushed once that edge has happened.
    task automatic step();
        exp_t e;
        int   ph;
        int   pf;
        e    = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        if (!nRST) begin
            m_run = 1'b0; m_t = 0; m_h = 0; m_v = 0;
            m_fc = '0; m_mode = '0; m_solid = '0;
        end else if (!en) begin
            m_run = 1'b0; m_h = 0; m_v = 0;
        end else begin
            if (!m_run) begin
                m_run = 1'b1;
                m_t   = 0;
            end else begin
                m_t++;
            end
            ph  = m_t % DIV;
            pf  = (m_t / DIV) % (HT * VT);
            m_h = pf % HT;
            m_v = pf / HT;
            e.fs = (ph == 0) && (pf == 0);
            if (e.fs) begin
                if (m_t != 0) m_fc = m_fc + 8'd1;
                m_mode  = mode;
                m_solid = solid_rgb;
            end
            e.clk = (ph >= 2);
            e.de  = (m_h < 16) && (m_v < 8);
            e.hs  = !((m_h >= 18) && (m_h <= 19));
            e.vs  = (m_v != 9);
            e.rgb = e.de ? pat(m_mode, m_solid, m_h, m_v) : 16'h0000;
        end
        e.fc = m_fc;
        @(posedge CLK);
        sb.push_back(e);
        #1;
    endtask

    initial begin : mon_px
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) check_px("px", actual(), sb.pop_front());
        end
    end

    initial begin : mon_w
        int   since;
        int   frames;
        int   idle;
        logic seen;
        since = 0; frames = 0; idle = 0; seen = 1'b0;
        while (!w_done) begin
            @(negedge CLK);
            if (fs_w) begin
                if (q_w.size() > 0) check_val("fcnt_w", fc_w, q_w.pop_front());
                if (seen) check_val("frame_len_w", since, 132);
                seen  = 1'b1;
                since = 0;
                frames++;
                if (frames == 258) w_done = 1'b1;
            end
            if (seen) begin
                if (since < 3) check_val("clk_odd_w", clk_w, (since != 0) ? 1 : 0);
                since++;
                if (since > 200) begin
                    check_val("frame_start_w timeout", since, 132);
                    w_done = 1'b1;
                end
            end else begin
                idle++;
                if (idle > 1000) begin
                    check_val("first frame_start_w timeout", idle, 4);
                    w_done = 1'b1;
                end
            end
        end
    end

    initial begin : stim
        exp_t w;
        int   guard;
        nRST = 1'b0; rst_w_n = 1'b0; en = 1'b1; mode = 2'd0; solid_rgb = 16'h0000;
        for (int i = 0; i < 258; i++) q_w.push_back(8'(i));
        repeat (3) step();
        nRST = 1'b1; rst_w_n = 1'b1;

        // Bars frame, then switch to solid red on line 3 of the following frame.
        repeat (968 + 10) step();
        for (int i = 0; i < 1000 && m_v != 3; i++) step();
        mode = 2'd3; solid_rgb = 16'hF800;
        repeat (968 * 2) step();
        mode = 2'd2;
        repeat (968) step();
        mode = 2'd1;
        repeat (968) step();

        // Asynchronous reset in the middle of a line.
        for (int i = 0; i < 200 && m_h != 5; i++) step();
        @(negedge CLK);
        #1 nRST = 1'b0;
        #1;
        w = '0; w.hs = 1'b1; w.vs = 1'b1;
        check_px("async_rst", actual(), w);
        step();
        step();
        nRST = 1'b1; mode = 2'd0;
        repeat (500) step();

        // Enable dropped mid-frame, then restored.
        en = 1'b0;
        repeat (100) step();
        en = 1'b1;
        repeat (968 * 2 + 10) step();
        @(negedge CLK);
        #1;

        guard = 0;
        while (!w_done && guard < 60000) begin
            @(posedge CLK);
            guard++;
        end
        if (!w_done) check_val("wrap_done timeout", guard, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
